// File: rtl/chip_io_unit.sv
// Chip-side feeder link endpoint: accepts load words into the accelerator's load
// memory, then starts the solver and streams the header and result rows back over the shared bus.
module chip_io_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              intrpt,
  input  logic              cmd,
  output logic              done,
  inout  wire  [DATA_W-1:0] data,
  output logic              ld_we,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ovf,
  output logic              proc_start,
  input  logic              acc_done,
  input  logic [3:0]        acc_t,
  input  logic [5:0]        acc_n,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_PROC_WAIT, S_HDR, S_STREAM, S_SEP, S_END
  } state_t;

  state_t              state_q, state_d;
  logic                ack_q, ack_d;
  logic                ld_we_q, ld_we_d;
  logic [ADDR_W:0]     ld_cnt_q, ld_cnt_d;
  logic [DATA_W-1:0]   ld_wdata_q, ld_wdata_d;
  logic                ld_ovf_q, ld_ovf_d;
  logic                start_q, start_d;
  logic                dwell_q, dwell_d;
  logic                pend_q, pend_d;
  logic [3:0]          t_q, t_d, r_q, r_d;
  logic [5:0]          n_q, n_d, c_q, c_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                data_oe;
  logic [DATA_W-1:0]   out_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      ld_we_q    <= 1'b0;
      ld_cnt_q   <= '0;
      ld_wdata_q <= '0;
      ld_ovf_q   <= 1'b0;
      start_q    <= 1'b0;
      dwell_q    <= 1'b0;
      pend_q     <= 1'b0;
      t_q        <= '0;
      n_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      ld_we_q    <= ld_we_d;
      ld_cnt_q   <= ld_cnt_d;
      ld_wdata_q <= ld_wdata_d;
      ld_ovf_q   <= ld_ovf_d;
      start_q    <= start_d;
      dwell_q    <= dwell_d;
      pend_q     <= pend_d;
      t_q        <= t_d;
      n_q        <= n_d;
      r_q        <= r_d;
      c_q        <= c_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    ld_we_d    = 1'b0;
    ld_cnt_d   = ld_cnt_q;
    ld_wdata_d = ld_wdata_q;
    ld_ovf_d   = ld_ovf_q;
    start_d    = 1'b0;
    dwell_d    = dwell_q;
    pend_d     = pend_q;
    t_d        = t_q;
    n_d        = n_q;
    r_d        = r_q;
    c_d        = c_q;
    ptr_d      = ptr_q;
    res_rd     = 1'b0;
    data_oe    = 1'b0;
    out_word   = '0;

    // Address advances after the write cycle; MSB of the count flags a full memory.
    if (ld_we_q) ld_cnt_d = ld_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!ack_q && intrpt) begin
          if (cmd) begin
            ack_d      = 1'b1;
            ld_wdata_d = data;
            if (ld_cnt_q[ADDR_W]) ld_ovf_d = 1'b1;
            else                  ld_we_d  = 1'b1;
          end else begin
            start_d = 1'b1;
            dwell_d = 1'b0;
            pend_d  = 1'b0;
            state_d = S_PROC_WAIT;
          end
        end
      end
      S_PROC_WAIT: begin
        // An early acc_done is remembered until the feeder has had two cycles to release the bus.
        dwell_d = 1'b1;
        if (acc_done) begin
          pend_d = 1'b1;
          t_d    = acc_t;
          n_d    = acc_n;
        end
        if (dwell_q && (acc_done || pend_q)) state_d = S_HDR;
      end
      S_HDR: begin
        data_oe  = 1'b1;
        out_word = {{(DATA_W-10){1'b0}}, n_q, t_q};
        if (t_q == 4'd0 || n_q == 6'd0) begin
          state_d = S_END;
        end else begin
          res_rd  = 1'b1;
          c_d     = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        data_oe  = 1'b1;
        out_word = res_rdata;
        if (c_q == n_q - 6'd1) begin
          state_d = S_SEP;
        end else begin
          c_d    = c_q + 6'd1;
          res_rd = 1'b1;
        end
      end
      S_SEP: begin
        data_oe = 1'b1;
        if (r_q != t_q - 4'd1) begin
          r_d     = r_q + 4'd1;
          c_d     = '0;
          res_rd  = 1'b1;
          state_d = S_STREAM;
        end else begin
          state_d = S_END;
        end
      end
      S_END: begin
        ld_cnt_d = '0;
        r_d      = '0;
        c_d      = '0;
        ptr_d    = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Result words are stored row-major, so reads simply walk a sequential pointer.
    if (res_rd) ptr_d = ptr_q + 1'b1;
  end

  assign data       = data_oe ? out_word : 'z;
  assign done       = ack_q | data_oe;
  assign ld_we      = ld_we_q;
  assign ld_addr    = ld_cnt_q[ADDR_W-1:0];
  assign ld_wdata   = ld_wdata_q;
  assign ld_ovf     = ld_ovf_q;
  assign proc_start = start_q;
  assign res_addr   = ptr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_chip_io_unit.sv
// Directed bench for chip_io_unit: loads, result streaming, early acc_done,
// empty result, load overflow on a small instance, and reset mid-stream.
module tb_chip_io_unit;

  logic        clk;
  logic        reset;
  logic        intrpt, cmd, acc_done;
  logic [3:0]  acc_t;
  logic [5:0]  acc_n;
  logic        done, ld_we, ld_ovf, proc_start, res_rd, busy;
  logic [9:0]  ld_addr, res_addr;
  logic [31:0] ld_wdata, res_rdata;
  logic [31:0] tb_drv;
  logic        tb_oe;
  wire  [31:0] data;

  logic        s_intrpt, s_cmd, s_done, s_ld_we, s_ld_ovf, s_proc_start, s_res_rd, s_busy;
  logic [1:0]  s_ld_addr, s_res_addr;
  logic [31:0] s_ld_wdata, s_drv;
  logic        zero1;
  logic [3:0]  zero4;
  logic [5:0]  zero6;
  logic [31:0] zero32;
  wire  [31:0] s_data;

  int n_cmp;
  int n_err;

  assign data   = tb_oe ? tb_drv : 'z;
  assign s_data = s_drv;

  chip_io_unit #(.DATA_W(32), .ADDR_W(10)) u_dut (
    .clk(clk), .reset(reset), .intrpt(intrpt), .cmd(cmd), .done(done), .data(data),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ovf(ld_ovf),
    .proc_start(proc_start), .acc_done(acc_done), .acc_t(acc_t), .acc_n(acc_n),
    .res_rd(res_rd), .res_addr(res_addr), .res_rdata(res_rdata), .busy(busy)
  );

  chip_io_unit #(.DATA_W(32), .ADDR_W(2)) u_small (
    .clk(clk), .reset(reset), .intrpt(s_intrpt), .cmd(s_cmd), .done(s_done), .data(s_data),
    .ld_we(s_ld_we), .ld_addr(s_ld_addr), .ld_wdata(s_ld_wdata), .ld_ovf(s_ld_ovf),
    .proc_start(s_proc_start), .acc_done(zero1), .acc_t(zero4), .acc_n(zero6),
    .res_rd(s_res_rd), .res_addr(s_res_addr), .res_rdata(zero32), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result memory: word at address a holds 0x10 + a, one-cycle read latency.
  always @(posedge clk) if (res_rd) res_rdata <= 32'h10 + 32'(res_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one load word and checks the ack cycle and the blackout cycle after it.
  task automatic load_dut(input logic [31:0] w, input logic [31:0] addr);
    tb_drv = w; tb_oe = 1'b1; intrpt = 1'b1; cmd = 1'b1;
    tick();
    chk("ld_done",  32'(done),  32'd1);
    chk("ld_we",    32'(ld_we), 32'd1);
    chk("ld_addr",  32'(ld_addr), addr);
    chk("ld_wdata", ld_wdata, w);
    tb_drv = 32'hBAD0_0BAD;
    tick();
    chk("blk_done",  32'(done),  32'd0);
    chk("blk_we",    32'(ld_we), 32'd0);
    chk("blk_addr",  32'(ld_addr), addr + 32'd1);
    chk("blk_wdata", ld_wdata, w);
    intrpt = 1'b0; tb_oe = 1'b0;
    tick();
  endtask

  task automatic bus_free(input string tag);
    tb_drv = 32'h5A5A_C3C3; tb_oe = 1'b1;
    #1;
    chk(tag, data, 32'h5A5A_C3C3);
    tb_oe = 1'b0;
  endtask

  logic [31:0] exp_stream [9];
  logic [31:0] wl [3];

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; intrpt = 1'b0; cmd = 1'b0; acc_done = 1'b0; acc_t = '0; acc_n = '0;
    tb_drv = '0; tb_oe = 1'b0; s_intrpt = 1'b0; s_cmd = 1'b0; s_drv = '0;
    zero1 = 1'b0; zero4 = '0; zero6 = '0; zero32 = '0;
    exp_stream = '{32'h32, 32'h10, 32'h11, 32'h12, 32'h0, 32'h13, 32'h14, 32'h15, 32'h0};
    wl = '{32'hA5A5_0001, 32'h2, 32'h3};
    tick(); tick();

    chk("rst_done",  32'(done), 32'd0);
    chk("rst_we",    32'(ld_we), 32'd0);
    chk("rst_addr",  32'(ld_addr), 32'd0);
    chk("rst_wdata", ld_wdata, 32'd0);
    chk("rst_ovf",   32'(ld_ovf), 32'd0);
    chk("rst_start", 32'(proc_start), 32'd0);
    chk("rst_rd",    32'(res_rd), 32'd0);
    chk("rst_raddr", 32'(res_addr), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_s_misc", {26'd0, s_proc_start, s_res_rd, s_res_addr, s_busy, s_done}, 32'd0);
    bus_free("rst_bus");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) load_dut(wl[i], 32'(i));

    // Process T=2 N=3 with acc_done arriving after the minimum dwell.
    intrpt = 1'b1; cmd = 1'b0;
    tick();
    chk("p_start", 32'(proc_start), 32'd1);
    chk("p_done0", 32'(done), 32'd0);
    chk("p_busy",  32'(busy), 32'd1);
    intrpt = 1'b0;
    tick();
    chk("p_start_off", 32'(proc_start), 32'd0);
    tick();
    chk("p_wait", 32'(done), 32'd0);
    acc_done = 1'b1; acc_t = 4'd2; acc_n = 6'd3;
    tick();
    acc_done = 1'b0;
    chk("hdr_rd",   32'(res_rd), 32'd1);
    chk("hdr_addr", 32'(res_addr), 32'd0);
    for (int i = 0; i < 9; i++) begin
      chk("str_done", 32'(done), 32'd1);
      chk("str_data", data, exp_stream[i]);
      tick();
    end
    chk("end_done", 32'(done), 32'd0);
    chk("end_busy", 32'(busy), 32'd1);
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ldaddr", 32'(ld_addr), 32'd0);
    bus_free("idle_bus");
    tick();

    // acc_done coincident with proc_start.
    intrpt = 1'b1; cmd = 1'b0;
    tick();
    intrpt = 1'b0; acc_done = 1'b1; acc_t = 4'd1; acc_n = 6'd1;
    tick();
    acc_done = 1'b0;
    chk("early_wait", 32'(done), 32'd0);
    tick();
    chk("early_hdr_done", 32'(done), 32'd1);
    chk("early_hdr", data, 32'h11);
    tick();
    chk("early_word", data, 32'h10);
    tick();
    chk("early_sep", data, 32'h0);
    tick();
    chk("early_end", 32'(done), 32'd0);
    tick();

    // T=0: header only.
    intrpt = 1'b1; cmd = 1'b0;
    tick();
    intrpt = 1'b0; acc_done = 1'b1; acc_t = 4'd0; acc_n = 6'd5;
    tick();
    acc_done = 1'b0;
    tick();
    chk("t0_hdr", data, 32'h50);
    chk("t0_done", 32'(done), 32'd1);
    chk("t0_rd", 32'(res_rd), 32'd0);
    tick();
    chk("t0_end", 32'(done), 32'd0);
    tick();
    chk("t0_idle", 32'(busy), 32'd0);

    // Overflow on the 4-word instance.
    for (int i = 0; i < 5; i++) begin
      s_drv = 32'h100 + 32'(i); s_intrpt = 1'b1; s_cmd = 1'b1;
      tick();
      chk("ovf_done", 32'(s_done), 32'd1);
      chk("ovf_we",   32'(s_ld_we), (i < 4) ? 32'd1 : 32'd0);
      chk("ovf_addr", 32'(s_ld_addr), 32'(i % 4));
      chk("ovf_flag", 32'(s_ld_ovf), (i == 4) ? 32'd1 : 32'd0);
      s_intrpt = 1'b0;
      tick(); tick();
    end

    // Reset in the middle of a stream.
    load_dut(32'h11, 32'd0);
    intrpt = 1'b1; cmd = 1'b0;
    tick();
    intrpt = 1'b0; acc_done = 1'b1; acc_t = 4'd2; acc_n = 6'd3;
    tick();
    acc_done = 1'b0;
    tick();
    tick();
    chk("mid_word", data, 32'h10);
    reset = 1'b1;
    #1;
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", 32'(ld_addr), 32'd0);
    bus_free("mid_rst_bus");
    #2;
    reset = 1'b0;
    tick();
    load_dut(32'h77, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
